serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 92 +++++++++
 tb/tb_serial_adder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder
// master drives operands and out_ready; slave is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one bit per clock, LSB first
// Optional signed overflow flag enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, carry_nxt, last_shift;

  assign bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_shift = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_shift)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured once on accept, so bus.a/bus.b are don't-care afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the last shift a_sr[0]/b_sr[0] are the original sign bits and bit_s is the sum sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      ovf_q <= 1'b0;
    end else if (state == SHIFT && last_shift) begin
      ovf_q <= (a_sr[0] == b_sr[0]) && (bit_s != a_sr[0]);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_sr;
  assign bus.cout      = carry;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (WIDTH=8)
// Expected ovf follows SERIAL_ADDER_OVF_EN.
module tb_serial_adder;
  localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();
  serial_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       o;
    int         hold;
    bit         early;
    bit         glitch;
  } vec_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got sum 0x%0h with no expected entry", bus.sum);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sb_sum", bus.sum, e.sum);
        check("sb_cout", bus.cout, e.cout);
        check("sb_ovf", bus.ovf, e.ovf);
      end
    end
  end

  task automatic do_op(input vec_t v);
    int   cnt;
    res_t e;
    cnt = 0;
    while (!bus.in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.in_valid  = 1'b1;
    bus.out_ready = v.early;
    e.sum  = v.s;
    e.cout = v.c;
    e.ovf  = OVF ? v.o : 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    check("in_ready_after_accept", bus.in_ready, 0);
    cnt = 0;
    while (!bus.out_valid && cnt < 4 * WIDTH) begin
      if (v.glitch) begin
        bus.in_valid = (cnt == 2 || cnt == 3);
        bus.a        = 8'h11;
        bus.b        = 8'h22;
      end
      @(posedge clk); #1;
      cnt++;
      if (v.glitch) check("in_ready_in_shift", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    check("latency", cnt, WIDTH);
    if (!v.early) begin
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", bus.out_valid, 1);
        check("hold_sum", bus.sum, v.s);
        check("hold_cout", bus.cout, v.c);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_after_handshake", bus.in_ready, 1);
    check("out_valid_drop", bus.out_valid, 0);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    //         a      b      sum    c     o     hold early glitch
    vecs.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1, 1'b0, 1'b0});
    vecs.push_back('{8'h3C, 8'h5A, 8'h96, 1'b0, 1'b1, 5, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0, 1'b1, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 2, 1'b0, 1'b0});
    vecs.push_back('{8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 0, 1'b1, 1'b0});
    vecs.push_back('{8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, 0, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // Abort 0xAA+0x55 with reset just before its 4th shift edge.
    bus.a        = 8'hAA;
    bus.b        = 8'h55;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_cout", bus.cout, 0);
    check("midrst_ovf", bus.ovf, 0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (3 * WIDTH) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check("no_valid_after_reset", seen, 0);

    v = '{8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    do_op(v);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
